// File: rtl/cla_add_arbiter.sv
// Shares one 8-bit carry-lookahead adder among NREQ valid/ready requesters; one operation in flight.
// Build option: define CLA_ARB_ROUND_ROBIN_EN for round-robin arbitration (default is fixed lowest-index priority).

module cla (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [31:0] s
);
  logic [7:0] g;
  logic [7:0] p;
  logic [8:0] c;
  logic [3:0] c_lo;
  logic [3:0] c_hi;

  // Carries c[k+1]..c[k+4] of a 4-bit group, fully expanded from the group carry-in.
  function automatic logic [3:0] look4(input logic [3:0] gg, input logic [3:0] pp, input logic ci);
    logic [3:0] co;
    co[0] = gg[0] | (pp[0] & ci);
    co[1] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & ci);
    co[2] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0]) | (pp[2] & pp[1] & pp[0] & ci);
    co[3] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1]) | (pp[3] & pp[2] & pp[1] & gg[0])
          | (pp[3] & pp[2] & pp[1] & pp[0] & ci);
    return co;
  endfunction

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    c_lo = look4(g[3:0], p[3:0], 1'b0);
    c_hi = look4(g[7:4], p[7:4], c_lo[3]);
    c    = {c_hi, c_lo, 1'b0};
  end

  assign s = {23'd0, c[8], p ^ c[7:0]};
endmodule

module cla_add_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [8*NREQ-1:0]   req_a,
  input  logic [8*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]     req_ready,
  output logic                rsp_valid,
  output logic [8:0]          rsp_sum,
  output logic [IDW-1:0]      rsp_id,
  input  logic                rsp_ready,
  output logic                busy,
  output logic [1:0]          dbg_state
);
  // Handshake: a request transfers in a cycle where req_valid[i] and req_ready[i] are both high;
  // a response transfers at the clock edge where rsp_valid and rsp_ready are both high.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [7:0]      op_a;
  logic [7:0]      op_b;
  logic [8:0]      sum_q;
  logic [IDW-1:0]  id_q;
  logic [IDW-1:0]  gnt_idx;
  logic            any_valid;
  logic            take;
  logic [7:0]      sel_a;
  logic [7:0]      sel_b;
  logic [31:0]     cla_s;
  logic            unused_s_hi;

  assign any_valid = |req_valid;

`ifdef CLA_ARB_ROUND_ROBIN_EN
  logic [IDW-1:0] ptr;
  logic [IDW:0]   cand;
  logic           found;

  // Search from ptr upward, wrapping at NREQ; first valid requester wins.
  always_comb begin
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ)) cand = cand - (IDW+1)'(NREQ);
      if (!found && req_valid[cand[IDW-1:0]]) begin
        found   = 1'b1;
        gnt_idx = cand[IDW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (take) begin
      if (gnt_idx == IDW'(NREQ-1)) ptr <= '0;
      else                         ptr <= gnt_idx + IDW'(1);
    end
  end
`else
  always_comb begin
    gnt_idx = '0;
    for (int i = NREQ-1; i >= 0; i--) begin
      if (req_valid[i]) gnt_idx = IDW'(i);
    end
  end
`endif

  assign take = (state_q == IDLE) && any_valid;

  always_comb begin
    req_ready = '0;
    if (take) req_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == IDW'(i)) begin
        sel_a = req_a[i*8 +: 8];
        sel_b = req_b[i*8 +: 8];
      end
    end
  end

  cla u_cla (
    .a (op_a),
    .b (op_b),
    .s (cla_s)
  );

  assign unused_s_hi = ^cla_s[31:9];

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    busy      = 1'b1;
    rsp_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (any_valid) state_d = EXEC;
      end
      EXEC: state_d = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath registers; a reset mid-operation simply drops whatever was captured.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a  <= '0;
      op_b  <= '0;
      id_q  <= '0;
      sum_q <= '0;
    end else begin
      if (take) begin
        op_a <= sel_a;
        op_b <= sel_b;
        id_q <= gnt_idx;
      end
      if (state_q == EXEC) sum_q <= cla_s[8:0];
    end
  end

  assign rsp_sum   = sum_q;
  assign rsp_id    = id_q;
  assign dbg_state = state_q;
endmodule

// File: tb/tb_cla_add_arbiter.sv
// Bench for cla_add_arbiter: directed cases then random transactions against a transaction-level model.

module tb_cla_add_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [8*NREQ-1:0]   req_a;
  logic [8*NREQ-1:0]   req_b;
  logic [NREQ-1:0]     req_ready;
  logic                rsp_valid;
  logic [8:0]          rsp_sum;
  logic [IDW-1:0]      rsp_id;
  logic                rsp_ready;
  logic                busy;
  logic [1:0]          unused_dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int ptr_m    = 0;
  logic [8:0] exp_q[$];
  int         id_m[$];

  cla_add_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_sum   (rsp_sum),
    .rsp_id    (rsp_id),
    .rsp_ready (rsp_ready),
    .busy      (busy),
    .dbg_state (unused_dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Winner: first valid at or above the pointer, else lowest valid overall.
  function automatic int pick(input logic [NREQ-1:0] m);
`ifdef CLA_ARB_ROUND_ROBIN_EN
    for (int i = ptr_m; i < NREQ; i++) if (m[i]) return i;
`endif
    for (int i = 0; i < NREQ; i++) if (m[i]) return i;
    return 0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"},  32'(busy), 0);
    chk({tag, "_rspv"},  32'(rsp_valid), 0);
    chk({tag, "_ready"}, 32'(req_ready), 0);
  endtask

  // One full operation from acceptance to response handshake; hold = cycles of backpressure.
  task automatic txn(input logic [NREQ-1:0] m, input logic [8*NREQ-1:0] av,
                     input logic [8*NREQ-1:0] bv, input int hold);
    int g;
    int id_e;
    logic [8:0] s_e;
    req_a = av;
    req_b = bv;
    req_valid = m;
    rsp_ready = 1'b0;
    @(negedge clk);
    g = pick(m);
    chk("accept_busy", 32'(busy), 0);
    chk("accept_ready", 32'(req_ready), 32'(1) << g);
    exp_q.push_back({1'b0, av[g*8 +: 8]} + {1'b0, bv[g*8 +: 8]});
    id_m.push_back(g);
    ptr_m = (g + 1) % NREQ;
    step();
    req_valid = NREQ'($urandom);
    req_a = $urandom;
    req_b = $urandom;
    @(negedge clk);
    chk("exec_busy", 32'(busy), 1);
    chk("exec_rspv", 32'(rsp_valid), 0);
    chk("exec_ready", 32'(req_ready), 0);
    step();
    req_valid = NREQ'($urandom);
    rsp_ready = (hold == 0);
    s_e  = exp_q.pop_front();
    id_e = id_m.pop_front();
    for (int c = 0; c <= hold; c++) begin
      @(negedge clk);
      chk("resp_valid", 32'(rsp_valid), 1);
      chk("resp_sum", 32'(rsp_sum), 32'(s_e));
      chk("resp_id", 32'(rsp_id), 32'(id_e));
      chk("resp_ready", 32'(req_ready), 0);
      chk("resp_busy", 32'(busy), 1);
      step();
      req_valid = NREQ'($urandom);
      rsp_ready = (c + 1 == hold);
    end
    req_valid = '0;
    rsp_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    ptr_m = 0;
    @(negedge clk);
    chk_idle("reset");
    chk("reset_sum", 32'(rsp_sum), 0);
    chk("reset_id", 32'(rsp_id), 0);
    step();

    // Carry-out into bit 8, requested in the first cycle after reset is released.
    rst = 1'b1;
    step();
    rst = 1'b0;
    txn(4'b0001, {8'd0, 8'd0, 8'd0, 8'd255}, {8'd0, 8'd0, 8'd0, 8'd1}, 0);

    // Back to back from requester 2: max sum then zero, rsp_ready high.
    txn(4'b0100, {8'd0, 8'd255, 8'd0, 8'd0}, {8'd0, 8'd255, 8'd0, 8'd0}, 0);
    txn(4'b0100, 32'd0, 32'd0, 0);

    // All four valid, A=i B=10.
    for (int k = 0; k < 5; k++)
      txn(4'b1111, {8'd3, 8'd2, 8'd1, 8'd0}, {8'd10, 8'd10, 8'd10, 8'd10}, 0);

    // Backpressure: response held for 5 cycles.
    txn(4'b0010, {8'd0, 8'd0, 8'd170, 8'd0}, {8'd0, 8'd0, 8'd85, 8'd0}, 5);
    @(negedge clk);
    chk_idle("after_bp");
    step();

    // Reset while in EXEC: operation dropped, pointer cleared.
    req_a = {8'd9, 8'd9, 8'd9, 8'd9};
    req_b = {8'd1, 8'd1, 8'd1, 8'd1};
    req_valid = 4'b0010;
    @(negedge clk);
    chk("pre_rst_ready", 32'(req_ready), 32'(1) << pick(4'b0010));
    step();
    req_valid = '0;
    @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    ptr_m = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk_idle("post_rst");
      chk("post_rst_sum", 32'(rsp_sum), 0);
      chk("post_rst_id", 32'(rsp_id), 0);
      step();
    end
    txn(4'b1111, {8'd3, 8'd2, 8'd1, 8'd0}, {8'd10, 8'd10, 8'd10, 8'd10}, 0);

    // Random traffic.
    for (int k = 0; k < 30; k++)
      txn(NREQ'($urandom_range(1, 15)), $urandom, $urandom, $urandom_range(0, 3));

    @(negedge clk);
    chk_idle("final");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no completion expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/cla_add_arbiter.md
# cla_add_arbiter

Shares the team's single 8-bit carry-lookahead adder `CLA` among `NREQ` requesters. Each requester offers one operand pair through a valid/ready handshake. The block grants one requester at a time, registers that requester's operands into the adder, and registers the 9-bit sum. It then presents the sum, with the winner's index, on a single shared response port until the consumer accepts it. It sits between the instruction/ALU front-ends and the `CLA` instance, so no front-end drives the adder directly.

## Interface
Parameters:
- `NREQ`, default 4: number of requesters; legal range 2..8.
- `IDW`, default 2: requester index width, equal to `$clog2(NREQ)`; minimum 1.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `req_valid` in NREQ: bit i is high when requester i offers an operand pair.
- `req_a` in 8*NREQ: operand A; requester i uses bits [8i+7:8i].
- `req_b` in 8*NREQ: operand B; same packing as `req_a`.
- `req_ready` out NREQ: one-hot acceptance pulse; bit i high means requester i's pair is taken this cycle.
- `rsp_valid` out 1: response held valid.
- `rsp_sum` out 9: A+B, where bit 8 is the adder carry-out `CLA.S[8]`.
- `rsp_id` out IDW: index of the requester that owns `rsp_sum`.
- `rsp_ready` in 1: consumer accepts the response.
- `busy` out 1: high in every state except IDLE.

## Operation
- One `CLA` instance.
  - Its A/B inputs are driven only from internal operand registers `op_a`/`op_b`.
  - `S[8:0]` is captured; `S[31:9]` is ignored.
- FSM with three states: IDLE, EXEC, RESP.
- IDLE:
  - If any `req_valid` is high, select winner g by the arbitration rule below.
  - Assert `req_ready[g]` combinationally in this cycle.
  - Capture `req_a[g]`, `req_b[g]` into `op_a`/`op_b`, capture g into `id_q`, and go to EXEC.
  - If no request is present, stay in IDLE with `req_ready` = 0.
- EXEC:
  - `CLA` evaluates `op_a`+`op_b`.
  - At the clock edge, capture `S[8:0]` into `sum_q` and go to RESP.
  - No request is accepted.
- RESP:
  - `rsp_valid` = 1; `rsp_sum` = `sum_q`; `rsp_id` = `id_q`.
  - All three are held stable until `rsp_ready` is high at a clock edge, then go to IDLE.
  - No request is accepted in RESP, including the handshake cycle.
- Arbitration applies only in IDLE; `req_valid` in other states is ignored, not queued.
- `req_ready` is never asserted for a requester whose `req_valid` is low, and is never multi-hot.
- Round-robin pointer `ptr` (IDW bits):
  - Search starts at `ptr` and wraps modulo NREQ; the first valid index wins.
  - On each grant, `ptr` ← (g+1) mod NREQ, with explicit wrap from NREQ-1 to 0.
- Arithmetic: unsigned 8+8 producing 9 bits; no overflow flag; `rsp_sum` range 0..510.
- Reset:
  - Reset in any state, including mid-EXEC or mid-RESP, forces IDLE.
  - The in-flight operation is discarded and no response is issued for it.
  - Reset values: `ptr`=0, `op_a`=`op_b`=0, `sum_q`=0, `id_q`=0.
  - Outputs after reset: `rsp_valid`=0, `rsp_sum`=0, `rsp_id`=0, `req_ready`=0, `busy`=0.
  - A `req_valid` present in the first cycle after `rst` deasserts is arbitrated normally.

## Timing
- Request accepted in cycle T (IDLE, `req_ready[g]`=1).
- Operands are registered at the end of T; the sum is registered at the end of T+1.
- `rsp_valid` rises in cycle T+2.
- Minimum latency from acceptance to response is 2 cycles.
- With `rsp_ready` tied high, RESP lasts 1 cycle; the block returns to IDLE in T+3 and can accept the next request in T+3.
- Peak throughput: one addition per 3 cycles.
- `req_ready` is a Mealy output of IDLE and `req_valid`; it has no combinational path from `rsp_ready`.
- `busy`, `rsp_valid`, `rsp_sum`, `rsp_id` are registered or decoded from state only.

## Configuration
- `CLA_ARB_ROUND_ROBIN_EN` defined:
  - Round-robin arbitration with `ptr` as described in Operation.
- `CLA_ARB_ROUND_ROBIN_EN` not defined:
  - Fixed priority; the lowest-index valid requester always wins.
  - `ptr` is not implemented.
  - All other behaviour and timing are identical.

## Test plan
- After reset, requester 0 sends A=255, B=1 → `req_ready[0]` in T; `rsp_valid` in T+2 with `rsp_sum`=9'h100 and `rsp_id`=0.
- Requester 2 sends A=255, B=255 and A=0, B=0 back to back with `rsp_ready`=1 → `rsp_sum`=510, then 0; the second acceptance occurs in T+3.
- All four requesters hold valid with A=i, B=10 (requester i):
  - With `CLA_ARB_ROUND_ROBIN_EN` → grant order is 0,1,2,3,0 and `rsp_sum` is 10,11,12,13,10.
  - Without the macro → `rsp_id` is always 0.
- Backpressure: `rsp_ready`=0 for 5 cycles during RESP with A=170, B=85 →
  - `rsp_sum`=255 and `rsp_id` stay stable;
  - `req_ready`=0 throughout;
  - return to IDLE one cycle after `rsp_ready` rises.
- Assert `rst` for 1 cycle in EXEC →
  - no `rsp_valid` is issued for the discarded operation;
  - all outputs take their reset values;
  - `ptr`=0, so with all four requesters valid the next grant goes to requester 0.
- Apply `req_valid` pulses during EXEC and RESP only → none are accepted, and `req_ready` stays 0.
